// File: rtl/bw_r_rf_pkg.sv
// Shared constants and helpers for the byte-enabled register file family.
package bw_r_rf_pkg;
  localparam int RDW_ZERO   = 0;
  localparam int RDW_BYPASS = 1;
  localparam int RDW_OLD    = 2;

  function automatic int nb(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/bw_r_rf_lane.sv
// One byte lane of the register file: DEPTH x 8 storage, write port, read port
// and the read-during-write mux. Storage is deliberately not reset.
module bw_r_rf_lane
  import bw_r_rf_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = RDW_ZERO
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wadr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] radr_i,
  input  logic              collide_i,
  output logic [7:0]        rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wadr_i] <= wdata_i;
  end

  // collide_i is only asserted for lanes being written to the read address
  always_comb begin
    rdata_o = mem_q[radr_i];
    if (collide_i) begin
      if (RDW_MODE == RDW_ZERO)        rdata_o = '0;
      else if (RDW_MODE == RDW_BYPASS) rdata_o = wdata_i;
    end
  end
endmodule

// File: rtl/bw_r_rf_bepar.sv
// 1R1W byte-enabled register file: S1 input staging, per-entry valid bits with
// flash clear, NB byte lanes and an optional registered output stage.
module bw_r_rf_bepar
  import bw_r_rf_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int WIDTH    = 160,
  parameter int RDW_MODE = RDW_ZERO,
  parameter int OUT_REG  = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_l_i,
  input  logic                    sehold_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_adr_i,
  input  logic [WIDTH-1:0]        din_i,
  input  logic [nb(WIDTH)-1:0]    byte_wen_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_W-1:0]       rd_adr_i,
  input  logic                    flash_clr_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic                    dout_vld_o,
  output logic                    rd_ack_o
);
  localparam int NB    = nb(WIDTH);
  localparam int DEPTH = 2 ** ADDR_W;

  logic              wr_en_q, rd_en_q, fclr_q;
  logic [ADDR_W-1:0] wr_adr_q, rd_adr_q;
  logic [WIDTH-1:0]  din_q;
  logic [NB-1:0]     be_q;
  logic [DEPTH-1:0]  vld_q, vld_d;

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      fclr_q   <= 1'b0;
      wr_adr_q <= '0;
      rd_adr_q <= '0;
      din_q    <= '0;
      be_q     <= '0;
    end else if (!sehold_i) begin
      wr_en_q  <= wr_en_i;
      rd_en_q  <= rd_en_i;
      fclr_q   <= flash_clr_i;
      wr_adr_q <= wr_adr_i;
      rd_adr_q <= rd_adr_i;
      din_q    <= din_i;
      be_q     <= byte_wen_i;
    end
  end

  // Write wins over a flash clear in the same cycle
  always_comb begin
    vld_d = vld_q;
    if (fclr_q) vld_d = '0;
    if (wr_en_q && |be_q) vld_d[wr_adr_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i)     vld_q <= '0;
    else if (!sehold_i) vld_q <= vld_d;
  end

  logic              collide, rd_vld;
  logic [NB-1:0][7:0] lane_rdata;
  logic [WIDTH-1:0]  rd_data;

  assign collide = rd_en_q & wr_en_q & (rd_adr_q == wr_adr_q);

  for (genvar k = 0; k < NB; k++) begin : g_lane
    bw_r_rf_lane #(.ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE)) u_lane (
      .clk_i    (clk_i),
      .we_i     (wr_en_q & be_q[k] & ~sehold_i),
      .wadr_i   (wr_adr_q),
      .wdata_i  (din_q[8*k +: 8]),
      .radr_i   (rd_adr_q),
      .collide_i(collide & be_q[k]),
      .rdata_o  (lane_rdata[k])
    );
  end

  assign rd_vld  = rd_en_q & ~fclr_q & (vld_q[rd_adr_q] | (collide & (|be_q)));
  assign rd_data = rd_vld ? lane_rdata : '0;

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] dout_q;
    logic             dvld_q, ack_q;

    always_ff @(posedge clk_i or negedge reset_l_i) begin
      if (!reset_l_i) begin
        dout_q <= '0;
        dvld_q <= 1'b0;
        ack_q  <= 1'b0;
      end else if (!sehold_i) begin
        dout_q <= rd_data;
        dvld_q <= rd_vld;
        ack_q  <= rd_en_q;
      end
    end

    assign dout_o     = dout_q;
    assign dout_vld_o = dvld_q;
    assign rd_ack_o   = ack_q;
  end else begin : g_comb
    assign dout_o     = rd_data;
    assign dout_vld_o = rd_vld;
    assign rd_ack_o   = rd_en_q;
  end
endmodule

// File: tb/tb_bw_r_rf_bepar.sv
// Directed bench: three OUT_REG=0 instances (one per RDW_MODE) plus one
// OUT_REG=1 instance, all driven from the same stimulus.
module tb_bw_r_rf_bepar;
  localparam int W = 160;

  logic         clk = 1'b0;
  logic         reset_l = 1'b0;
  logic         sehold = 1'b0;
  logic         wr_en = 1'b0, rd_en = 1'b0, flash_clr = 1'b0;
  logic [3:0]   wr_adr = '0, rd_adr = '0;
  logic [W-1:0] din = '0;
  logic [19:0]  byte_wen = '0;

  logic [W-1:0] dout [4];
  logic         vld  [4];
  logic         ack  [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bw_r_rf_bepar #(.RDW_MODE(0), .OUT_REG(0)) u_m0 (
    .clk_i(clk), .reset_l_i(reset_l), .sehold_i(sehold), .wr_en_i(wr_en), .wr_adr_i(wr_adr),
    .din_i(din), .byte_wen_i(byte_wen), .rd_en_i(rd_en), .rd_adr_i(rd_adr),
    .flash_clr_i(flash_clr), .dout_o(dout[0]), .dout_vld_o(vld[0]), .rd_ack_o(ack[0]));
  bw_r_rf_bepar #(.RDW_MODE(1), .OUT_REG(0)) u_m1 (
    .clk_i(clk), .reset_l_i(reset_l), .sehold_i(sehold), .wr_en_i(wr_en), .wr_adr_i(wr_adr),
    .din_i(din), .byte_wen_i(byte_wen), .rd_en_i(rd_en), .rd_adr_i(rd_adr),
    .flash_clr_i(flash_clr), .dout_o(dout[1]), .dout_vld_o(vld[1]), .rd_ack_o(ack[1]));
  bw_r_rf_bepar #(.RDW_MODE(2), .OUT_REG(0)) u_m2 (
    .clk_i(clk), .reset_l_i(reset_l), .sehold_i(sehold), .wr_en_i(wr_en), .wr_adr_i(wr_adr),
    .din_i(din), .byte_wen_i(byte_wen), .rd_en_i(rd_en), .rd_adr_i(rd_adr),
    .flash_clr_i(flash_clr), .dout_o(dout[2]), .dout_vld_o(vld[2]), .rd_ack_o(ack[2]));
  bw_r_rf_bepar #(.RDW_MODE(0), .OUT_REG(1)) u_r (
    .clk_i(clk), .reset_l_i(reset_l), .sehold_i(sehold), .wr_en_i(wr_en), .wr_adr_i(wr_adr),
    .din_i(din), .byte_wen_i(byte_wen), .rd_en_i(rd_en), .rd_adr_i(rd_adr),
    .flash_clr_i(flash_clr), .dout_o(dout[3]), .dout_vld_o(vld[3]), .rd_ack_o(ack[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flash_clr = 1'b0; byte_wen = '0; din = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [W-1:0] d, input logic [19:0] be);
    wr_en = 1'b1; wr_adr = a; din = d; byte_wen = be;
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en = 1'b1; rd_adr = a;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dout[i] !== '0 || vld[i] !== 1'b0 || ack[i] !== 1'b0) begin
        bad++; $display("FAIL reset_state[%0d] got=%h/%b/%b exp=0/0/0", i, dout[i], vld[i], ack[i]);
      end
    end
    @(negedge clk) reset_l = 1'b1;
    do_read(4'd3); step(); idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout[i] !== '0 || vld[i] !== 1'b0 || ack[i] !== 1'b1) begin
        bad++; $display("FAIL read_unwritten[%0d] got=%h/%b/%b exp=0/0/1", i, dout[i], vld[i], ack[i]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [W-1:0] e;
    e = {20{8'hA5}};
    do_write(4'd5, e, '1); step(); idle();
    do_read(4'd5); step(); idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout[i] !== e || vld[i] !== 1'b1) begin
        bad++; $display("FAIL write_read[%0d] got=%h/%b exp=%h/1", i, dout[i], vld[i], e);
      end
    end
    total++;
    if (ack[3] !== 1'b0) begin bad++; $display("FAIL oreg_lat1 ack got=%b exp=0", ack[3]); end
    step();
    total++;
    if (dout[3] !== e || vld[3] !== 1'b1 || ack[3] !== 1'b1) begin
      bad++; $display("FAIL oreg_lat2 got=%h/%b/%b exp=%h/1/1", dout[3], vld[3], ack[3], e);
    end
    total++;
    if (ack[0] !== 1'b0 || dout[0] !== '0) begin
      bad++; $display("FAIL no_read got=%h/%b exp=0/0", dout[0], ack[0]);
    end
  endtask

  task automatic test_partial();
    logic [W-1:0] e;
    e = {{19{8'hA5}}, 8'h3C};
    do_write(4'd5, {{19{8'hFF}}, 8'h3C}, 20'h00001); step(); idle();
    do_read(4'd5); step(); idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout[i] !== e || vld[i] !== 1'b1) begin
        bad++; $display("FAIL partial[%0d] got=%h/%b exp=%h/1", i, dout[i], vld[i], e);
      end
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] e [3];
    logic [W-1:0] after;
    e[0]  = {{19{8'h11}}, 8'h00};
    e[1]  = {{19{8'h11}}, 8'h22};
    e[2]  = {{19{8'h11}}, 8'h11};
    after = {{19{8'h11}}, 8'h22};
    do_write(4'd7, {20{8'h11}}, '1); step(); idle(); step();
    do_write(4'd7, {20{8'h22}}, 20'h00001); do_read(4'd7); step(); idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout[i] !== e[i] || vld[i] !== 1'b1) begin
        bad++; $display("FAIL collide_mode%0d got=%h/%b exp=%h/1", i, dout[i], vld[i], e[i]);
      end
    end
    do_read(4'd7); step(); idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout[i] !== after) begin
        bad++; $display("FAIL collide_after[%0d] got=%h exp=%h", i, dout[i], after);
      end
    end
  endtask

  task automatic test_flash();
    logic [W-1:0] e;
    e = {20{8'h5A}};
    flash_clr = 1'b1; do_write(4'd2, e, '1); do_read(4'd7); step(); idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout[i] !== '0 || vld[i] !== 1'b0 || ack[i] !== 1'b1) begin
        bad++; $display("FAIL flash_read[%0d] got=%h/%b/%b exp=0/0/1", i, dout[i], vld[i], ack[i]);
      end
    end
    do_read(4'd5); step(); idle();
    total++;
    if (dout[0] !== '0 || vld[0] !== 1'b0) begin
      bad++; $display("FAIL flash_cleared got=%h/%b exp=0/0", dout[0], vld[0]);
    end
    do_read(4'd2); step(); idle();
    total++;
    if (dout[0] !== e || vld[0] !== 1'b1) begin
      bad++; $display("FAIL flash_wr_survives got=%h/%b exp=%h/1", dout[0], vld[0], e);
    end
  endtask

  task automatic test_sehold();
    logic [W-1:0] e2, e9;
    e2 = {20{8'h5A}};
    e9 = {20{8'h77}};
    do_read(4'd2); do_write(4'd9, e9, '1); step(); step();
    sehold = 1'b1; rd_adr = 4'd9; wr_adr = 4'd2; din = {20{8'hEE}};
    step(); step(); step();
    total++;
    if (dout[0] !== e2 || vld[0] !== 1'b1 || ack[0] !== 1'b1) begin
      bad++; $display("FAIL sehold_s1 got=%h/%b/%b exp=%h/1/1", dout[0], vld[0], ack[0], e2);
    end
    total++;
    if (dout[3] !== e2 || vld[3] !== 1'b1 || ack[3] !== 1'b1) begin
      bad++; $display("FAIL sehold_oreg got=%h/%b/%b exp=%h/1/1", dout[3], vld[3], ack[3], e2);
    end
    sehold = 1'b0; idle(); step();
    total++;
    if (ack[0] !== 1'b0 || ack[3] !== 1'b1 || dout[3] !== e2) begin
      bad++; $display("FAIL sehold_release got=%b/%b/%h exp=0/1/%h", ack[0], ack[3], dout[3], e2);
    end
    do_read(4'd9); step(); idle();
    total++;
    if (dout[0] !== e9 || vld[0] !== 1'b1) begin
      bad++; $display("FAIL sehold_held_write got=%h/%b exp=%h/1", dout[0], vld[0], e9);
    end
    do_read(4'd2); step(); idle();
    total++;
    if (dout[0] !== e2) begin
      bad++; $display("FAIL sehold_no_leak got=%h exp=%h", dout[0], e2);
    end
  endtask

  task automatic test_reset_midwrite();
    do_read(4'd2); step();
    do_write(4'd4, {20{8'h99}}, '1); step(); idle();
    #2 reset_l = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dout[i] !== '0 || vld[i] !== 1'b0 || ack[i] !== 1'b0) begin
        bad++; $display("FAIL async_reset[%0d] got=%h/%b/%b exp=0/0/0", i, dout[i], vld[i], ack[i]);
      end
    end
    @(posedge clk);
    @(negedge clk) reset_l = 1'b1;
    do_read(4'd4); step(); idle();
    total++;
    if (dout[0] !== '0 || vld[0] !== 1'b0 || ack[0] !== 1'b1) begin
      bad++; $display("FAIL dropped_write got=%h/%b/%b exp=0/0/1", dout[0], vld[0], ack[0]);
    end
    do_read(4'd2); step(); idle();
    total++;
    if (vld[0] !== 1'b0) begin
      bad++; $display("FAIL reset_clears_vld got=%b exp=0", vld[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_collision();
    test_flash();
    test_sehold();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
